// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter
//   Shares the single SDRAM command port between VGA scan-out reads, drawing
//   engine writes and periodic refresh. One command is in flight at a time.
//   A command is presented with mem_cmd_valid until mem_cmd_ready, then the
//   arbiter waits for mem_done. After that it returns a one-cycle grant to the
//   requester that owned the command.
//
//   Optional build macro: DRAW_FAIRNESS_EN
//     When defined, after MAX_VGA_BURST consecutive VGA grants taken while draw
//     was waiting, draw wins the next decision. When undefined, priority is
//     strictly refresh > VGA > draw, and MAX_VGA_BURST has no effect.
//
// Ports
//   clk, rst                  memory-domain clock, synchronous active-high reset
//   vga_req/vga_addr          VGA read request (held until vga_gnt)
//   vga_gnt/vga_rdata         read-done pulse and its data
//   draw_req/draw_addr/data   draw write request (held until draw_gnt)
//   draw_gnt                  write-done pulse
//   mem_cmd_valid/cmd/addr/wdata, mem_cmd_ready   command handshake to controller
//   mem_done/mem_rdata        completion pulse and read data from controller
//   refresh_overrun           sticky: refresh interval expired with two owed

module sdram_access_arbiter #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int REFRESH_CYCLES = 1040,
  parameter int MAX_VGA_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_data,
  output logic              draw_gnt,
  output logic              mem_cmd_valid,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_cmd_ready,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              refresh_overrun
);

  localparam logic [1:0] CMD_READ    = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_REFRESH = 2'b10;

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic [RW-1:0]   ref_cnt;
  logic [1:0]      owed;

  logic wrap;
  logic refresh_done;
  logic grant_pending;
  logic draw_first;
  logic pick_refresh;
  logic pick_vga;
  logic pick_draw;

  // ---------------------------------------------------------------------------
  // Refresh timer and owed-refresh bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wrap         = (ref_cnt == REF_LAST);
    refresh_done = (state == WAIT) && mem_done && (mem_cmd == CMD_REFRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt         <= '0;
      owed            <= '0;
      refresh_overrun <= 1'b0;
    end else begin
      ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
      case ({wrap, refresh_done})
        2'b10:   if (owed != 2'd2) owed <= owed + 2'd1;
        2'b01:   owed <= owed - 2'd1;
        default: owed <= owed;
      endcase
      if (wrap && (owed == 2'd2))
        refresh_overrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  // The cycle a grant pulse is visible, the requester has not yet had a
  // chance to drop its held request, so no decision is taken in that cycle.
  always_comb begin
    grant_pending = vga_gnt | draw_gnt;
    pick_refresh  = (owed != 2'd0);
    pick_vga      = !pick_refresh && vga_req && !draw_first;
    pick_draw     = !pick_refresh && draw_req && (!vga_req || draw_first);
  end

`ifdef DRAW_FAIRNESS_EN
  localparam int SW = $clog2(MAX_VGA_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VGA_BURST);

  logic [SW-1:0] streak;

  always_comb begin
    draw_first = draw_req && (streak == STREAK_MAX);
  end

  // Streak counts VGA wins that made a waiting draw request wait longer.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if ((state == IDLE) && !grant_pending) begin
      if (pick_draw)
        streak <= '0;
      else if (pick_vga)
        streak <= !draw_req ? '0 :
                  (streak == STREAK_MAX) ? streak : streak + 1'b1;
    end
  end
`else
  always_comb begin
    draw_first = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Command FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_cmd_valid <= 1'b0;
      mem_cmd       <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      vga_gnt       <= 1'b0;
      draw_gnt      <= 1'b0;
      vga_rdata     <= '0;
    end else begin
      vga_gnt  <= 1'b0;
      draw_gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (!grant_pending) begin
            if (pick_refresh) begin
              mem_cmd       <= CMD_REFRESH;
              mem_addr      <= '0;
              mem_wdata     <= '0;
              mem_cmd_valid <= 1'b1;
              state         <= ISSUE;
            end else if (pick_vga) begin
              mem_cmd       <= CMD_READ;
              mem_addr      <= vga_addr;
              mem_wdata     <= '0;
              mem_cmd_valid <= 1'b1;
              state         <= ISSUE;
            end else if (pick_draw) begin
              mem_cmd       <= CMD_WRITE;
              mem_addr      <= draw_addr;
              mem_wdata     <= draw_data;
              mem_cmd_valid <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_done) begin
            state <= IDLE;
            case (mem_cmd)
              CMD_READ: begin
                vga_gnt   <= 1'b1;
                vga_rdata <= mem_rdata;
              end
              CMD_WRITE: draw_gnt <= 1'b1;
              default:   ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed testbench for sdram_access_arbiter. The bench plays the SDRAM
// controller and both requesters; expected values are hand-derived.
// Build with +define+DRAW_FAIRNESS_EN to exercise the fairness variant.

module tb_sdram_access_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int REF    = 1040;
  localparam int BURST  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic [DATA_W-1:0] vga_rdata;
  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_data;
  logic              draw_gnt;
  logic              mem_cmd_valid;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_cmd_ready;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              refresh_overrun;

  sdram_access_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .REFRESH_CYCLES(REF),
    .MAX_VGA_BURST (BURST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .vga_req        (vga_req),
    .vga_addr       (vga_addr),
    .vga_gnt        (vga_gnt),
    .vga_rdata      (vga_rdata),
    .draw_req       (draw_req),
    .draw_addr      (draw_addr),
    .draw_data      (draw_data),
    .draw_gnt       (draw_gnt),
    .mem_cmd_valid  (mem_cmd_valid),
    .mem_cmd        (mem_cmd),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_cmd_ready  (mem_cmd_ready),
    .mem_done       (mem_done),
    .mem_rdata      (mem_rdata),
    .refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  int unsigned tcount = 0;
  int unsigned t_rst  = 0;
  always @(posedge clk) tcount <= tcount + 1;

  int checks = 0;
  int errors = 0;

  // Transaction observations returned by run_txn
  bit                 to;
  bit                 early;
  bit                 vg;
  bit                 dg;
  logic [1:0]         cmd_o;
  logic [ADDR_W-1:0]  addr_o;
  logic [DATA_W-1:0]  wdata_o;
  logic [DATA_W-1:0]  rd_o;
  int unsigned        k_o;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycles since reset release, counted in edges.
  function automatic int unsigned k_now();
    return tcount - t_rst;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    vga_req = 1'b0; vga_addr = '0;
    draw_req = 1'b0; draw_addr = '0; draw_data = '0;
    mem_cmd_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    cyc();
    cyc();
    rst = 1'b0;
    t_rst = tcount;
  endtask

  // Acts as the controller for one command: waits (bounded) for valid,
  // accepts it, completes it one cycle later, and reports what was seen.
  task automatic run_txn(input logic [DATA_W-1:0] rdata, input int max_wait);
    to = 1'b0; early = 1'b0; vg = 1'b0; dg = 1'b0;
    cmd_o = '0; addr_o = '0; wdata_o = '0; rd_o = '0; k_o = 0;
    for (int i = 0; i < max_wait && !mem_cmd_valid; i++) begin
      if (vga_gnt || draw_gnt) early = 1'b1;
      cyc();
    end
    if (!mem_cmd_valid) begin
      to = 1'b1;
      return;
    end
    k_o = k_now();
    cmd_o = mem_cmd; addr_o = mem_addr; wdata_o = mem_wdata;
    mem_cmd_ready = 1'b1;
    cyc();
    mem_cmd_ready = 1'b0;
    mem_done = 1'b1; mem_rdata = rdata;
    cyc();
    mem_done = 1'b0; mem_rdata = '0;
    vg = vga_gnt; dg = draw_gnt; rd_o = vga_rdata;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_cmd_valid, mem_cmd, vga_gnt, draw_gnt, refresh_overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {mem_cmd_valid, mem_cmd, vga_gnt, draw_gnt, refresh_overrun});
    end
    checks++;
    if ({mem_addr, mem_wdata, vga_rdata} !== {(ADDR_W + 2 * DATA_W){1'b0}}) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", mem_addr, mem_wdata, vga_rdata);
    end
    cyc(); cyc(); cyc();
    checks++;
    if (mem_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_cmd: valid %b want 0", mem_cmd_valid);
    end
  endtask

  task automatic test_refresh_timer();
    do_reset();
    run_txn(32'h0, 1100);
    checks++;
    if (to || cmd_o !== 2'b10 || addr_o !== '0 || wdata_o !== '0 || k_o != 1041) begin
      errors++;
      $display("FAIL refresh1: to %0b cmd %b addr %h wdata %h at %0d want cmd 10 addr 0 wdata 0 at 1041",
               to, cmd_o, addr_o, wdata_o, k_o);
    end
    checks++;
    if (early || vg || dg) begin
      errors++;
      $display("FAIL refresh1_gnt: early %b vga %b draw %b want 000", early, vg, dg);
    end
    run_txn(32'h0, 1100);
    checks++;
    if (to || cmd_o !== 2'b10 || k_o != 2081) begin
      errors++;
      $display("FAIL refresh2: to %0b cmd %b at %0d want cmd 10 at 2081", to, cmd_o, k_o);
    end
    checks++;
    if (early || vg || dg || refresh_overrun !== 1'b0) begin
      errors++;
      $display("FAIL refresh2_side: early %b vga %b draw %b overrun %b want 0000",
               early, vg, dg, refresh_overrun);
    end
  endtask

  task automatic test_vga_before_draw();
    do_reset();
    vga_req = 1'b1; vga_addr = 23'h00ABC;
    draw_req = 1'b1; draw_addr = 23'h00123; draw_data = 32'hDEADBEEF;
    run_txn(32'h1234_5678, 20);
    checks++;
    if (to || cmd_o !== 2'b00 || addr_o !== 23'h00ABC || wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL first_read: cmd %b addr %h wdata %h want 00 00abc 0", cmd_o, addr_o, wdata_o);
    end
    checks++;
    if (vg !== 1'b1 || dg !== 1'b0 || rd_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_gnt: vga %b draw %b rdata %h want 1 0 12345678", vg, dg, rd_o);
    end
    vga_req = 1'b0;
    cyc();
    checks++;
    if (vga_gnt !== 1'b0) begin
      errors++;
      $display("FAIL gnt_pulse_width: vga_gnt %b want 0", vga_gnt);
    end
    run_txn(32'h0, 20);
    checks++;
    if (to || cmd_o !== 2'b01 || addr_o !== 23'h00123 || wdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write: cmd %b addr %h wdata %h want 01 00123 deadbeef", cmd_o, addr_o, wdata_o);
    end
    checks++;
    if (vg !== 1'b0 || dg !== 1'b1) begin
      errors++;
      $display("FAIL write_gnt: vga %b draw %b want 0 1", vg, dg);
    end
    draw_req = 1'b0;
  endtask

  task automatic test_stall();
    bit stable_ok;
    do_reset();
    vga_req = 1'b1; vga_addr = 23'h7FFFFF;
    for (int i = 0; i < 10 && !mem_cmd_valid; i++) cyc();
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mem_cmd_valid !== 1'b1 || mem_cmd !== 2'b00 || mem_addr !== 23'h7FFFFF) stable_ok = 1'b0;
      cyc();
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL stall_stable: valid %b cmd %b addr %h want 1 00 7fffff held", mem_cmd_valid, mem_cmd, mem_addr);
    end
    mem_cmd_ready = 1'b1;
    cyc();
    mem_cmd_ready = 1'b0;
    checks++;
    if (mem_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: valid %b want 0", mem_cmd_valid);
    end
    mem_done = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    cyc();
    mem_done = 1'b0; mem_rdata = '0;
    checks++;
    if (vga_gnt !== 1'b1 || vga_rdata !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stall_gnt: gnt %b rdata %h want 1 ffffffff", vga_gnt, vga_rdata);
    end
    vga_req = 1'b0;
  endtask

  task automatic test_refresh_first();
    do_reset();
    draw_req = 1'b1; draw_addr = 23'h00555; draw_data = 32'hA5A5_0001;
    for (int i = 0; i < 10 && !mem_cmd_valid; i++) cyc();
    mem_cmd_ready = 1'b1;
    cyc();
    mem_cmd_ready = 1'b0;
    vga_req = 1'b1; vga_addr = 23'h00ABC;
    while (k_now() < 1045) cyc();
    mem_done = 1'b1;
    cyc();
    mem_done = 1'b0;
    checks++;
    if (draw_gnt !== 1'b1) begin
      errors++;
      $display("FAIL held_write_gnt: draw_gnt %b want 1", draw_gnt);
    end
    draw_req = 1'b0;
    run_txn(32'h0, 20);
    checks++;
    if (to || cmd_o !== 2'b10 || vg || dg) begin
      errors++;
      $display("FAIL refresh_wins: cmd %b vga %b draw %b want 10 0 0", cmd_o, vg, dg);
    end
    run_txn(32'hCAFE_F00D, 20);
    checks++;
    if (to || cmd_o !== 2'b00 || addr_o !== 23'h00ABC || !vg || rd_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL vga_after_refresh: cmd %b addr %h gnt %b rdata %h want 00 00abc 1 cafef00d",
               cmd_o, addr_o, vg, rd_o);
    end
    vga_req = 1'b0;
  endtask

  task automatic test_overrun();
    bit quiet;
    do_reset();
    for (int i = 0; i < 1100 && !mem_cmd_valid; i++) cyc();
    mem_cmd_ready = 1'b1;
    cyc();
    mem_cmd_ready = 1'b0;
    while (k_now() < 3119) cyc();
    checks++;
    if (refresh_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_early: %b want 0 at 3119", refresh_overrun);
    end
    cyc();
    checks++;
    if (refresh_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: %b want 1 at 3120", refresh_overrun);
    end
    mem_done = 1'b1;
    cyc();
    mem_done = 1'b0;
    run_txn(32'h0, 20);
    checks++;
    if (to || cmd_o !== 2'b10) begin
      errors++;
      $display("FAIL owed_second: to %b cmd %b want refresh", to, cmd_o);
    end
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_cmd_valid) quiet = 1'b0;
      cyc();
    end
    checks++;
    if (!quiet || refresh_overrun !== 1'b1) begin
      errors++;
      $display("FAIL owed_drained: quiet %b overrun %b want 1 1", quiet, refresh_overrun);
    end
  endtask

  task automatic test_fairness();
    bit exp_v;
    bit seq_ok;
    string got;
    do_reset();
    vga_req = 1'b1; vga_addr = 23'h00010;
    draw_req = 1'b1; draw_addr = 23'h00020; draw_data = 32'h0000_0042;
    seq_ok = 1'b1;
    got = "";
    for (int i = 0; i < 10; i++) begin
`ifdef DRAW_FAIRNESS_EN
      exp_v = ((i % 5) != 4);
`else
      exp_v = 1'b1;
`endif
      run_txn(32'h0, 20);
      got = {got, to ? "T" : (vg ? "V" : (dg ? "D" : "-"))};
      if (to || vg !== exp_v || dg !== !exp_v) seq_ok = 1'b0;
    end
    checks++;
    if (!seq_ok) begin
      errors++;
`ifdef DRAW_FAIRNESS_EN
      $display("FAIL grant_sequence: got %s want VVVVDVVVVD", got);
`else
      $display("FAIL grant_sequence: got %s want VVVVVVVVVV", got);
`endif
    end
    vga_req = 1'b0; draw_req = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_rst_mid();
    do_reset();
    vga_req = 1'b1; vga_addr = 23'h00777;
    for (int i = 0; i < 10 && !mem_cmd_valid; i++) cyc();
    mem_cmd_ready = 1'b1;
    cyc();
    mem_cmd_ready = 1'b0;
    vga_req = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({mem_cmd_valid, mem_cmd, vga_gnt, draw_gnt} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL rst_mid_out: valid %b cmd %b addr %h gnts %b%b want all 0",
               mem_cmd_valid, mem_cmd, mem_addr, vga_gnt, draw_gnt);
    end
    mem_done = 1'b1; mem_rdata = 32'h5555_AAAA;
    cyc();
    mem_done = 1'b0; mem_rdata = '0;
    checks++;
    if (vga_gnt !== 1'b0 || draw_gnt !== 1'b0 || vga_rdata !== '0 || mem_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_done: gnt %b%b rdata %h valid %b want 0 0 0 0",
               vga_gnt, draw_gnt, vga_rdata, mem_cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_vga_before_draw();
    test_stall();
    test_rst_mid();
    test_fairness();
    test_refresh_timer();
    test_refresh_first();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
